c1_reduce_arbiter: RTL and testbench
====================================

Name: c1_reduce_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one multi-cycle C1-cell reduction unit (N-input AND/OR chain) among NREQ requesters.
- Picks one requester, pulses a start to the shared unit, holds the grant until the unit signals done, then rotates priority.
- Sits between requesting datapath blocks and the single reduction resource, so that only one requester drives the unit's operands at any time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, grant index width; must equal clog2(NREQ).
- TIMEOUT, 15, max WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  level request per requester; held until its grant is seen
- gnt  output  NREQ  one-hot grant; all-zero when idle
- gnt_id  output  IDW  binary index of current grant; valid while busy=1
- unit_start  output  1  one-cycle pulse launching the shared unit
- unit_done  input  1  one-cycle pulse from the shared unit: result valid
- op_done  output  1  one-cycle pulse to the granted requester, same cycle gnt drops
- busy  output  1  high from GRANT through RELEASE
- err  output  1  timeout abort pulse; tied 0 when the optional feature is absent

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_id=0, unit_start=0, op_done=0, busy=0, err=0, pointer=NREQ-1 (so requester 0 wins first).
- FSM states: IDLE, GRANT, WAIT, RELEASE.
- IDLE:
  - If req!=0, choose the first set bit scanning from pointer+1 upward, wrapping modulo NREQ.
  - Register gnt/gnt_id; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: unit_start=1 for exactly this cycle; busy=1; go to WAIT.
- WAIT:
  - Hold gnt.
  - On unit_done=1, go to RELEASE.
  - A unit_done during GRANT is ignored. The unit must not complete in 0 cycles.
- RELEASE:
  - op_done=1; gnt=0; pointer<=gnt_id; busy=0 from the next cycle.
  - Go to IDLE.
- Latency: request at cycle t in IDLE gives gnt at t+1 and unit_start at t+1. Minimum turnaround is 4 cycles per operation, including the IDLE arbitration cycle.
- Fairness: with all requests held, grants rotate 0,1,2,3,0,...; no requester waits more than NREQ-1 operations.
- Requester drops req while granted: the grant is held until done. The arbiter never aborts on req deassert.
- New requests arriving during busy are sampled only in IDLE.
- Only the lowest IDW bits of the pointer are used; wrap from NREQ-1 to 0.
- Invariant: gnt is at most one-hot at all times; gnt_id matches gnt while busy.

Optional Feature:
- Macro: C1_ARB_TIMEOUT_EN.
- Defined:
  - An IDW+2-bit-wide (at least 4-bit) watchdog counts WAIT cycles, cleared on entering WAIT.
  - If the count reaches TIMEOUT without unit_done: err=1 for one cycle, then go to RELEASE with op_done=0.
  - The pointer still advances.
  - A unit_done in the same cycle as the timeout wins: normal completion, err=0.
- Undefined: no counter is built; err is tied 0; WAIT lasts indefinitely.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'b00, GRANT=2'b01, WAIT=2'b10, RELEASE=2'b11;
  - default NREQ, IDW and TIMEOUT constants.
- One sub-module, rr_pick:
  - combinational rotate-priority picker (req, pointer -> one-hot plus index, plus any flag);
  - the only combinational logic outside the FSM;
  - reusable by other shared-resource controllers.

Test Plan:
- Reset: rst_n low mid-WAIT with gnt=4'b0100 -> same cycle gnt=0, busy=0, unit_start=0. After release, req=4'b1111 grants requester 0 first.
- Rotation: req=4'b1111 held, unit_done 2 cycles after each unit_start -> gnt sequence 0001,0010,0100,1000,0001, each with exactly one unit_start and one op_done.
- Skip and wrap: pointer=2, req=4'b0011 -> gnt=4'b0001. Next with req=4'b0011 -> gnt=4'b0010.
- Handshake: req=4'b0100 at cycle 0 -> gnt=4'b0100 and unit_start at cycle 1. Stray unit_done at cycle 1 is ignored. unit_done at cycle 5 -> op_done and gnt=0 at cycle 6, busy=0 at cycle 7.
- Req drop: requester 1 deasserts req in WAIT -> gnt stays 4'b0010 until unit_done; no early release.
- Timeout (C1_ARB_TIMEOUT_EN, TIMEOUT=15): no unit_done -> err pulses at the 15th WAIT cycle, op_done=0, next grant goes to the next requester. unit_done coincident with the timeout -> err=0 and op_done=1.

Source files
------------

// File: rtl/c1_reduce_arbiter_pkg.sv
// Shared definitions for the C1 reduction-unit arbiter: FSM state encodings and default sizing.
package c1_reduce_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    WAIT    = 2'b10,
    RELEASE = 2'b11
  } arb_state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_IDW     = 2;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/c1_reduce_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request strictly after pointer, wrapping modulo NREQ.
module rr_pick
  import c1_reduce_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  pointer,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    onehot   = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Scanning offsets 1..NREQ puts the last-served requester at lowest priority.
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(pointer) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!any && req[cand_idx]) begin
        any              = 1'b1;
        onehot[cand_idx] = 1'b1;
        idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/c1_reduce_arbiter.sv
// Round-robin sequencer sharing one multi-cycle C1 reduction unit among NREQ requesters.
// Optional WAIT watchdog abort is enabled by defining C1_ARB_TIMEOUT_EN.
module c1_reduce_arbiter
  import c1_reduce_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int IDW     = DEF_IDW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            unit_start,
  input  logic            unit_done,
  output logic            op_done,
  output logic            busy,
  output logic            err
);

  arb_state_t      state_reg, state_next;
  logic [NREQ-1:0] gnt_reg;
  logic [IDW-1:0]  gnt_id_reg;
  logic [IDW-1:0]  pointer_reg;
  logic [NREQ-1:0] pick_onehot;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            timeout_hit;
  logic            aborted;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .pointer(pointer_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef C1_ARB_TIMEOUT_EN
  localparam int WDW = (IDW + 2 < 4) ? 4 : IDW + 2;

  logic [WDW-1:0] wd_reg;
  logic           abort_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_reg    <= '0;
      abort_reg <= 1'b0;
    end else begin
      if (state_reg == GRANT)
        wd_reg <= '0;
      else if (state_reg == WAIT)
        wd_reg <= wd_reg + 1'b1;
      abort_reg <= timeout_hit;
    end
  end

  // A unit_done landing on the timeout cycle counts as a normal completion.
  assign timeout_hit = (state_reg == WAIT) && !unit_done && (wd_reg == WDW'(TIMEOUT - 1));
  assign aborted     = abort_reg;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign aborted        = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    unit_start = 1'b0;
    op_done    = 1'b0;
    busy       = 1'b1;
    err        = timeout_hit;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (pick_any) state_next = GRANT;
      end
      GRANT: begin
        unit_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (unit_done || timeout_hit) state_next = RELEASE;
      end
      RELEASE: begin
        op_done    = !aborted;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      pointer_reg <= IDW'(NREQ - 1);
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            gnt_reg    <= pick_onehot;
            gnt_id_reg <= pick_idx;
          end
        end
        WAIT: begin
          if (state_next == RELEASE) gnt_reg <= '0;
        end
        RELEASE: pointer_reg <= gnt_id_reg;
        default: ;
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;

endmodule

// File: tb/tb_c1_reduce_arbiter.sv
// Scoreboard bench for c1_reduce_arbiter: directed grants pushed to queues, monitor pops on start/done/err.
module tb_c1_reduce_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       unit_start;
  logic       unit_done;
  logic       op_done;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
  } gexp_t;

  typedef struct {
    bit op;
    bit er;
  } eexp_t;

  gexp_t gnt_q[$];
  eexp_t end_q[$];

  c1_reduce_arbiter #(
    .NREQ   (4),
    .IDW    (2),
    .TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .unit_start(unit_start),
    .unit_done (unit_done),
    .op_done   (op_done),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: sim time exceeded, required finish");
    $fatal(1, "bench hung");
  end

  // Monitor: pops the scoreboard whenever the DUT launches or completes an operation.
  always @(negedge clk) begin
    gexp_t ge;
    eexp_t ee;
    if (rst_n) begin
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("FAIL onehot: gnt=%b required at most one bit", gnt);
      end
      if (unit_start) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: gnt=%b required no start", gnt);
        end else begin
          ge = gnt_q.pop_front();
          $display("grant gnt=%b gnt_id=%0d at %0t", gnt, gnt_id, $time);
          if (gnt !== ge.g || gnt_id !== ge.id || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant: gnt=%b id=%0d busy=%b required gnt=%b id=%0d busy=1",
                     gnt, gnt_id, busy, ge.g, ge.id);
          end
        end
      end
      if (op_done || err) begin
        checks++;
        if (end_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_end: op_done=%b err=%b required neither", op_done, err);
        end else begin
          ee = end_q.pop_front();
          $display("end op_done=%b err=%b gnt=%b at %0t", op_done, err, gnt, $time);
          if (op_done !== ee.op || err !== ee.er || (op_done && gnt !== 4'b0000)) begin
            errors++;
            $display("FAIL end: op_done=%b err=%b gnt=%b required op_done=%b err=%b",
                     op_done, err, gnt, ee.op, ee.er);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic wait_start();
    int n;
    n = 0;
    while (!unit_start && n < 20) begin
      tick();
      n++;
    end
    check("start_seen", {31'd0, unit_start}, 32'd1);
  endtask

  // One operation: request, expect grant, answer with unit_done `delay` cycles after unit_start.
  task automatic run_op(input logic [3:0] r, input logic [3:0] eg, input int delay, input bit drop);
    req = r;
    gnt_q.push_back('{eg, id_of(eg)});
    end_q.push_back('{1'b1, 1'b0});
    wait_start();
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold_gnt", {28'd0, gnt}, {28'd0, eg});
      if (drop && i == 0) req = 4'b0000;
    end
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    check("op_done_cycle", {31'd0, op_done}, 32'd1);
    tick();
  endtask

  initial begin
    rst_n     = 1'b1;
    req       = 4'b0000;
    unit_done = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    check("rst_gnt",   {28'd0, gnt}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, unit_start}, 32'd0);
    check("rst_opdone",{31'd0, op_done}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Rotation with all requests held.
    run_op(4'b1111, 4'b0001, 2, 1'b0);
    run_op(4'b1111, 4'b0010, 2, 1'b0);
    run_op(4'b1111, 4'b0100, 2, 1'b0);
    run_op(4'b1111, 4'b1000, 2, 1'b0);
    run_op(4'b1111, 4'b0001, 2, 1'b0);

    // Move pointer to 2, then skip and wrap.
    run_op(4'b0100, 4'b0100, 1, 1'b0);
    run_op(4'b0011, 4'b0001, 2, 1'b0);
    run_op(4'b0011, 4'b0010, 2, 1'b0);

    // Requester 1 drops req during WAIT; grant must hold until done.
    run_op(4'b0010, 4'b0010, 5, 1'b1);

    // Cycle-exact handshake with a stray unit_done during GRANT.
    req = 4'b0100;
    gnt_q.push_back('{4'b0100, 2'd2});
    end_q.push_back('{1'b1, 1'b0});
    tick();
    check("hs_c1_gnt",   {28'd0, gnt}, 32'h4);
    check("hs_c1_start", {31'd0, unit_start}, 32'd1);
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    req       = 4'b0000;
    check("hs_c2_start", {31'd0, unit_start}, 32'd0);
    check("hs_c2_gnt",   {28'd0, gnt}, 32'h4);
    check("hs_c2_opdone",{31'd0, op_done}, 32'd0);
    tick();
    tick();
    check("hs_c4_gnt",   {28'd0, gnt}, 32'h4);
    tick();
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    check("hs_c6_opdone",{31'd0, op_done}, 32'd1);
    check("hs_c6_gnt",   {28'd0, gnt}, 32'd0);
    check("hs_c6_busy",  {31'd0, busy}, 32'd1);
    tick();
    check("hs_c7_busy",  {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of WAIT.
    req = 4'b0100;
    gnt_q.push_back('{4'b0100, 2'd2});
    wait_start();
    tick();
    tick();
    check("mid_wait_gnt", {28'd0, gnt}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt",   {28'd0, gnt}, 32'd0);
    check("arst_busy",  {31'd0, busy}, 32'd0);
    check("arst_start", {31'd0, unit_start}, 32'd0);
    req = 4'b1111;
    tick();
    rst_n = 1'b1;
    run_op(4'b1111, 4'b0001, 2, 1'b0);

`ifdef C1_ARB_TIMEOUT_EN
    // No unit_done: abort on the 15th WAIT cycle.
    req = 4'b1111;
    gnt_q.push_back('{4'b0010, 2'd1});
    end_q.push_back('{1'b0, 1'b1});
    wait_start();
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("to_err", {31'd0, err}, {31'd0, (k == 15)});
    end
    tick();
    check("to_rel_opdone", {31'd0, op_done}, 32'd0);
    check("to_rel_gnt",    {28'd0, gnt}, 32'd0);
    tick();
    run_op(4'b1111, 4'b0100, 2, 1'b0);

    // unit_done coincident with the timeout wins.
    gnt_q.push_back('{4'b1000, 2'd3});
    end_q.push_back('{1'b1, 1'b0});
    wait_start();
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 15) begin
        unit_done = 1'b1;
        #1;
      end
      check("co_err", {31'd0, err}, 32'd0);
    end
    tick();
    unit_done = 1'b0;
    check("co_opdone", {31'd0, op_done}, 32'd1);
    tick();
`else
    check("err_tied", {31'd0, err}, 32'd0);
`endif

    req = 4'b0000;
    tick();
    tick();
    check("queues_empty", gnt_q.size() + end_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
